// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: debounced clock, 11-bit framing, optional E0/F0
// prefix folding, and a show-ahead FIFO towards the CPU-side register.
module ps2_rx_fifo #(
  parameter int DEBOUNCE_LEN   = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE         = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          rd_clr_overflow,
  output logic [9:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          err_parity,
  output logic                          err_framing,
  output logic                          err_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

  logic                    data_meta_q, sdata_q;
  logic [DEBOUNCE_LEN:0]   stable_q, stable_d;
  logic                    bitclk_q, bitclk_d, bitedge;
  state_t                  state_q, state_d;
  logic [8:0]              shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic                    accept_q, accept_d;
  logic                    err_par_q, err_par_d, err_frm_q, err_frm_d, err_to_q, err_to_d;
  logic                    ext_q, ext_d, brk_q, brk_d;
  logic                    push;
  logic [9:0]              push_data;
  logic [9:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    full, empty, pop_ok, push_ok;

  // bitclk tracks the shift register's next contents so that bitedge lasts one cycle.
  assign stable_d = {stable_q[DEBOUNCE_LEN-1:0], ps2_clk};
  always_comb begin
    bitclk_d = bitclk_q;
    if (&stable_d)            bitclk_d = 1'b1;
    else if (stable_d == '0)  bitclk_d = 1'b0;
  end
  assign bitedge = bitclk_q & (stable_q[DEBOUNCE_LEN-1:0] == '0);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bitcnt_d = bitcnt_q;
    tcnt_d   = tcnt_q;
    accept_d = 1'b0;
    err_par_d = 1'b0;
    err_frm_d = 1'b0;
    err_to_d  = 1'b0;
    if (state_q == S_IDLE || bitedge) begin
      tcnt_d = '0;
    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tcnt_d   = '0;
      state_d  = S_IDLE;
      err_to_d = 1'b1;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
    if (bitedge) begin
      case (state_q)
        S_IDLE: if (!sdata_q) begin
          state_d  = S_DATA;
          shift_d  = '0;
          parity_d = 1'b0;
          bitcnt_d = '0;
        end
        S_DATA: begin
          shift_d  = {sdata_q, shift_q[8:1]};
          parity_d = parity_q ^ sdata_q;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd8) state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!sdata_q)       err_frm_d = 1'b1;
          else if (!parity_q) err_par_d = 1'b1;
          else                accept_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decode works on the registered accept, so shift_q[7:0] is still the received byte.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    push_data = {2'b00, shift_q[7:0]};
    if (DECODE != 0) begin
      push_data = {brk_q, ext_q, shift_q[7:0]};
      if (err_par_q || err_frm_q || err_to_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (accept_q) begin
        if (shift_q[7:0] == 8'hE0)      ext_d = 1'b1;
        else if (shift_q[7:0] == 8'hF0) brk_d = 1'b1;
        else begin
          push  = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
    end else begin
      push = accept_q;
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (push && full && !pop_ok) overflow_d = 1'b1;
    else if (rd_clr_overflow)    overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta_q <= 1'b1;
      sdata_q     <= 1'b1;
      stable_q    <= '0;
      bitclk_q    <= 1'b0;
      state_q     <= S_IDLE;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bitcnt_q    <= '0;
      tcnt_q      <= '0;
      accept_q    <= 1'b0;
      err_par_q   <= 1'b0;
      err_frm_q   <= 1'b0;
      err_to_q    <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      data_meta_q <= ps2_data;
      sdata_q     <= data_meta_q;
      stable_q    <= stable_d;
      bitclk_q    <= bitclk_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bitcnt_q    <= bitcnt_d;
      tcnt_q      <= tcnt_d;
      accept_q    <= accept_d;
      err_par_q   <= err_par_d;
      err_frm_q   <= err_frm_d;
      err_to_q    <= err_to_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign rd_valid    = ~empty;
  assign rd_data     = empty ? 10'd0 : mem_q[rd_ptr_q];
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign err_parity  = err_par_q;
  assign err_framing = err_frm_q;
  assign err_timeout = err_to_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a decoding instance (depth 4) and a raw instance share the pins.
module tb_ps2_rx_fifo;
  localparam int DL    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 300;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       rd_en = 1'b0, rd_clr = 1'b0, raw_rd_en = 1'b0;
  logic [9:0] rd_data, raw_rd_data;
  logic       rd_valid, raw_rd_valid;
  logic [2:0] fifo_count, raw_fifo_count;
  logic       overflow, err_parity, err_framing, err_timeout;
  logic       raw_overflow, raw_err_parity, raw_err_framing, raw_err_timeout;

  int n_checks = 0, n_fail = 0;
  int n_par = 0, n_frm = 0, n_to = 0;
  logic [9:0] exp_q[$];
  logic [9:0] raw_q[$];
  bit m_ext, m_brk, m_ovf;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEBOUNCE_LEN(DL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .DECODE(1)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .rd_clr_overflow(rd_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .overflow(overflow), .err_parity(err_parity),
    .err_framing(err_framing), .err_timeout(err_timeout));

  ps2_rx_fifo #(.DEBOUNCE_LEN(DL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .DECODE(0)) dut_raw (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(raw_rd_en), .rd_clr_overflow(1'b0), .rd_data(raw_rd_data), .rd_valid(raw_rd_valid),
    .fifo_count(raw_fifo_count), .overflow(raw_overflow), .err_parity(raw_err_parity),
    .err_framing(raw_err_framing), .err_timeout(raw_err_timeout));

  always @(posedge clk) begin
    if (err_parity)  n_par <= n_par + 1;
    if (err_framing) n_frm <= n_frm + 1;
    if (err_timeout) n_to  <= n_to + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; raw_rd_en = 1'b0; rd_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (DL + 5) @(posedge clk);
    #1;
    exp_q.delete(); raw_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic bit_out(input logic v);
    @(posedge clk); #1 ps2_data = v;
    repeat (HALF) @(posedge clk); #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk); #1 ps2_clk = 1'b1;
  endtask

  // Leaves ps2_clk low; the caller is #1 after the edge that first samples the stop-bit fall.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) bit_out(fr[i]);
    @(posedge clk); #1 ps2_data = fr[10];
    repeat (HALF) @(posedge clk); #1 ps2_clk = 1'b0;
  endtask

  task automatic finish_frame();
    repeat (HALF) @(posedge clk); #1 ps2_clk = 1'b1;
    repeat (HALF) @(posedge clk); #1;
  endtask

  task automatic model(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      if (raw_q.size() < DEPTH) raw_q.push_back({2'b00, b});
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (exp_q.size() < DEPTH) exp_q.push_back({m_brk, m_ext, b});
        else m_ovf = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_frame(b, bad_par, bad_stop);
    finish_frame();
    model(b, bad_par | bad_stop);
    $display("frame byte=%h bad_par=%0d bad_stop=%0d", b, bad_par, bad_stop);
  endtask

  task automatic pop_one(input bit raw, output logic [9:0] d, output logic v);
    v = raw ? raw_rd_valid : rd_valid;
    d = raw ? raw_rd_data : rd_data;
    if (raw) raw_rd_en = v; else rd_en = v;
    @(posedge clk); #1;
    rd_en = 1'b0; raw_rd_en = 1'b0;
    $display("pop raw=%0d valid=%0d data=%h", raw, v, d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rd_valid, fifo_count, rd_data, overflow, err_parity, err_framing, err_timeout} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b count=%0d data=%h ovf=%b errs=%b%b%b, required all zero",
               rd_valid, fifo_count, rd_data, overflow, err_parity, err_framing, err_timeout);
    end
    do_reset();
    n_checks++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_release: valid=%b count=%0d, required 0/0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_single();
    logic [9:0] d; logic v;
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (DL + 1) @(posedge clk); #1;
    n_checks++;
    if (rd_valid !== 1'b0 || err_parity !== 1'b0 || err_framing !== 1'b0) begin
      n_fail++; $display("FAIL single_n1: valid=%b par=%b frm=%b, required 0 0 0", rd_valid, err_parity, err_framing);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 10'h01C || fifo_count !== 3'd1) begin
      n_fail++; $display("FAIL single_n2: valid=%b data=%h count=%0d, required 1 01c 1", rd_valid, rd_data, fifo_count);
    end
    finish_frame();
    pop_one(1'b0, d, v);
    n_checks++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL single_pop: valid=%b count=%0d, required 0 0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_decode();
    logic [9:0] d; logic v; logic [9:0] e;
    do_reset();
    xfer(8'hE0, 0, 0); xfer(8'hF0, 0, 0); xfer(8'h75, 0, 0);
    n_checks++;
    if (fifo_count !== 3'd1) begin
      n_fail++; $display("FAIL decode_count: count=%0d, required 1", fifo_count);
    end
    xfer(8'h75, 0, 0);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      pop_one(1'b0, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL decode_pop%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      e = raw_q.pop_front();
      pop_one(1'b1, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL raw_pop%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      end
    end
  endtask

  task automatic test_errors();
    logic [9:0] d; logic v; logic [9:0] e;
    int p0, f0, t0;
    do_reset();
    p0 = n_par; f0 = n_frm; t0 = n_to;
    xfer(8'hE0, 0, 0);
    xfer(8'h1C, 1, 0);
    n_checks++;
    if (n_par != p0 + 1 || n_frm != f0 || n_to != t0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL err_parity: par=%0d frm=%0d to=%0d count=%0d, required %0d %0d %0d 0",
                         n_par - p0, n_frm - f0, n_to - t0, fifo_count, 1, 0, 0);
    end
    xfer(8'h1C, 0, 1);
    n_checks++;
    if (n_par != p0 + 1 || n_frm != f0 + 1 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL err_framing: par=%0d frm=%0d count=%0d, required 1 1 0",
                         n_par - p0, n_frm - f0, fifo_count);
    end
    xfer(8'h1C, 0, 0);
    e = exp_q.pop_front();
    pop_one(1'b0, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_fail++; $display("FAIL err_flagclr: valid=%b data=%h, required 1 %h", v, d, e);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] d; logic v; logic [9:0] e;
    int t0, waited; bit seen;
    do_reset();
    xfer(8'hE0, 0, 0);
    t0 = n_to;
    bit_out(1'b0); bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    seen = 1'b0; waited = 0;
    while (!seen && waited < 2 * TO) begin
      @(posedge clk); #1;
      waited++;
      if (n_to != t0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL timeout_seen: no err_timeout within %0d cycles, required one pulse", 2 * TO);
    end
    repeat (20) @(posedge clk); #1;
    n_checks++;
    if (n_to != t0 + 1 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL timeout_pulse: pulses=%0d count=%0d, required 1 0", n_to - t0, fifo_count);
    end
    model(8'h00, 1'b1);
    xfer(8'h29, 0, 0);
    e = exp_q.pop_front();
    pop_one(1'b0, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== e) begin
      n_fail++; $display("FAIL timeout_next: valid=%b data=%h, required 1 %h", v, d, e);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] d; logic v; logic [9:0] e;
    logic [7:0] codes [5];
    codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h26; codes[3] = 8'h25; codes[4] = 8'h2E;
    do_reset();
    for (int i = 0; i < 5; i++) xfer(codes[i], 0, 0);
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== m_ovf) begin
      n_fail++; $display("FAIL ovf_full: count=%0d ovf=%b, required 4 %b", fifo_count, overflow, m_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      pop_one(1'b0, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL ovf_pop%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      end
    end
    rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL empty_pop: valid=%b count=%0d ovf=%b, required 0 0 1", rd_valid, fifo_count, overflow);
    end
    rd_clr = 1'b1;
    @(posedge clk); #1 rd_clr = 1'b0;
    m_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
    end
    for (int i = 0; i < 4; i++) xfer(codes[i], 0, 0);
    send_frame(codes[4], 0, 0);
    repeat (DL + 1) @(posedge clk); #1;
    e = exp_q.pop_front();
    rd_en = 1'b1;
    n_checks++;
    if (rd_data !== e) begin
      n_fail++; $display("FAIL simul_head: data=%h, required %h", rd_data, e);
    end
    @(posedge clk); #1 rd_en = 1'b0;
    exp_q.push_back({2'b00, codes[4]});
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL simul_pushpop: count=%0d ovf=%b, required 4 0", fifo_count, overflow);
    end
    finish_frame();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      pop_one(1'b0, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++; $display("FAIL simul_drain%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] d; logic v; logic [9:0] e;
    int p0, f0, t0;
    do_reset();
    xfer(8'h16, 0, 0);
    p0 = n_par; f0 = n_frm; t0 = n_to;
    bit_out(1'b0);
    for (int i = 0; i < 5; i++) bit_out(i[0]);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({rd_valid, fifo_count, rd_data, overflow, err_parity, err_framing, err_timeout} !== 17'd0) begin
      n_fail++; $display("FAIL midreset_state: valid=%b count=%0d data=%h ovf=%b, required all zero",
                         rd_valid, fifo_count, rd_data, overflow);
    end
    reset = 1'b0;
    exp_q.delete(); raw_q.delete(); m_ext = 1'b0; m_brk = 1'b0;
    repeat (TO + 50) @(posedge clk); #1;
    xfer(8'h1C, 0, 0);
    e = exp_q.pop_front();
    pop_one(1'b0, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== e || n_par != p0 || n_frm != f0 || n_to != t0) begin
      n_fail++; $display("FAIL midreset_next: valid=%b data=%h errs=%0d/%0d/%0d, required 1 %h 0/0/0",
                         v, d, n_par - p0, n_frm - f0, n_to - t0, e);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_decode();
    test_errors();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
